axi_lite_reg_bridge: RTL and testbench

AXI4-Lite slave that converts one AXI-Lite transaction at a time into a request/ready register-bus access. It sits between the peripheral crossbar and register-mapped peripherals such as timers and interrupt controllers. It supports slave wait states, byte strobes, fair read/write arbitration, decode errors for out-of-range addresses, and an optional access timeout. Read data is registered, so it stays stable while `r_valid` is held.

---
 rtl/axi_lite_reg_pkg.sv | 44 ++++
 rtl/axi_lite_reg_timer.sv | 25 ++
 rtl/axi_lite_reg_bridge.sv | 170 +++++++++++++++++
 tb/tb_axi_lite_reg_bridge.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_reg_pkg.sv
// Shared types and constants for the AXI4-Lite to register-bus bridge.
// The request/response structs are the default channel types used by axi_lite_reg_bridge.
package axi_lite_reg_pkg;

    localparam int unsigned AXI_AW = 64;
    localparam int unsigned AXI_DW = 64;

    typedef enum logic [2:0] {
        IDLE,
        WDATA,
        REG_WR,
        REG_RD,
        BRESP,
        RRESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [AXI_AW-1:0]   aw_addr;
        logic                aw_valid;
        logic [AXI_DW-1:0]   w_data;
        logic [AXI_DW/8-1:0] w_strb;
        logic                w_valid;
        logic                b_ready;
        logic [AXI_AW-1:0]   ar_addr;
        logic                ar_valid;
        logic                r_ready;
    } axi_lite_req_t;

    typedef struct packed {
        logic              aw_ready;
        logic              w_ready;
        logic [1:0]        b_resp;
        logic              b_valid;
        logic              ar_ready;
        logic [AXI_DW-1:0] r_data;
        logic [1:0]        r_resp;
        logic              r_valid;
    } axi_lite_resp_t;

endpackage

// File: rtl/axi_lite_reg_timer.sv
// Clearable saturating wait counter; limit_o flags that LIMIT idle cycles have elapsed.
module axi_lite_reg_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic limit_o
);

    logic [15:0] count_q;

    assign limit_o = (count_q == 16'(LIMIT));

    // NOTE: sequential state is updated with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (inc_i && !limit_o) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: rtl/axi_lite_reg_bridge.sv
// AXI4-Lite slave to request/ready register-bus bridge, one transaction in flight.
// Define AXI_LITE_REG_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES on reg_ready_i.
module axi_lite_reg_bridge
    import axi_lite_reg_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned REG_BYTES      = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter type         axi_req_t      = axi_lite_req_t,
    parameter type         axi_resp_t     = axi_lite_resp_t
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  axi_req_t                    axi_req_i,
    output axi_resp_t                   axi_resp_o,
    output logic [AXI_ADDR_WIDTH-1:0]   reg_addr_o,
    output logic                        reg_valid_o,
    output logic                        reg_write_o,
    output logic [AXI_DATA_WIDTH-1:0]   reg_wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0] reg_wstrb_o,
    input  logic [AXI_DATA_WIDTH-1:0]   reg_rdata_i,
    input  logic                        reg_ready_i,
    input  logic                        reg_error_i
);

    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH-1:0] WORD_MASK  = ~AXI_ADDR_WIDTH'(STRB_WIDTH - 1);
    localparam logic [AXI_ADDR_WIDTH-1:0] WINDOW_END = AXI_ADDR_WIDTH'(REG_BYTES);

    state_e                    state_q, state_d;
    logic                      last_write_q, last_write_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
    logic                      write_q, write_d;
    logic [1:0]                resp_q, resp_d;
    logic                      write_sel, timeout;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr, ar_addr;

    assign aw_addr = AXI_ADDR_WIDTH'(axi_req_i.aw_addr);
    assign ar_addr = AXI_ADDR_WIDTH'(axi_req_i.ar_addr);

    // A contested IDLE cycle goes to the direction not served last time.
    assign write_sel = axi_req_i.aw_valid && (!axi_req_i.ar_valid || !last_write_q);

    assign reg_valid_o = (state_q == REG_WR) || (state_q == REG_RD);
    assign reg_addr_o  = addr_q;
    assign reg_write_o = write_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wstrb_o = wstrb_q;

`ifdef AXI_LITE_REG_TIMEOUT_EN
    axi_lite_reg_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (!reg_valid_o),
        .inc_i   (reg_valid_o && !reg_ready_i),
        .limit_o (timeout)
    );
`else
    logic [15:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 16'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        last_write_d = last_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        write_d      = write_q;
        rdata_d      = rdata_q;
        resp_d       = resp_q;
        axi_resp_o        = '0;
        axi_resp_o.b_resp = resp_q;
        axi_resp_o.r_resp = resp_q;
        axi_resp_o.r_data = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (write_sel) begin
                    axi_resp_o.aw_ready = 1'b1;
                    addr_d       = aw_addr & WORD_MASK;
                    write_d      = 1'b1;
                    last_write_d = 1'b1;
                    resp_d       = (aw_addr >= WINDOW_END) ? RESP_DECERR : RESP_OKAY;
                    if (axi_req_i.w_valid) begin
                        axi_resp_o.w_ready = 1'b1;
                        wdata_d = axi_req_i.w_data;
                        wstrb_d = axi_req_i.w_strb;
                        state_d = (aw_addr >= WINDOW_END) ? BRESP : REG_WR;
                    end else begin
                        state_d = WDATA;
                    end
                end else if (axi_req_i.ar_valid) begin
                    axi_resp_o.ar_ready = 1'b1;
                    addr_d       = ar_addr & WORD_MASK;
                    write_d      = 1'b0;
                    wstrb_d      = '0;
                    last_write_d = 1'b0;
                    if (ar_addr >= WINDOW_END) begin
                        resp_d  = RESP_DECERR;
                        rdata_d = '0;
                        state_d = RRESP;
                    end else begin
                        resp_d  = RESP_OKAY;
                        state_d = REG_RD;
                    end
                end
            end
            WDATA: begin
                // resp_q already carries the decode verdict taken when AW was captured.
                axi_resp_o.w_ready = axi_req_i.w_valid;
                if (axi_req_i.w_valid) begin
                    wdata_d = axi_req_i.w_data;
                    wstrb_d = axi_req_i.w_strb;
                    state_d = (resp_q == RESP_DECERR) ? BRESP : REG_WR;
                end
            end
            REG_WR, REG_RD: begin
                if (reg_ready_i) begin
                    resp_d = reg_error_i ? RESP_SLVERR : RESP_OKAY;
                    if (state_q == REG_RD) rdata_d = reg_rdata_i;
                    state_d = (state_q == REG_WR) ? BRESP : RRESP;
                end else if (timeout) begin
                    resp_d  = RESP_SLVERR;
                    rdata_d = '0;
                    state_d = (state_q == REG_WR) ? BRESP : RRESP;
                end
            end
            BRESP: begin
                axi_resp_o.b_valid = 1'b1;
                if (axi_req_i.b_ready) state_d = IDLE;
            end
            RRESP: begin
                axi_resp_o.r_valid = 1'b1;
                if (axi_req_i.r_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_write_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            write_q      <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= RESP_OKAY;
        end else begin
            state_q      <= state_d;
            last_write_q <= last_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            write_q      <= write_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// Self-checking bench for axi_lite_reg_bridge: directed scenarios plus randomized
// transactions checked against a transaction-level model of the bridge.
module tb_axi_lite_reg_bridge;
    import axi_lite_reg_pkg::*;

    localparam int unsigned REG_BYTES = 8192;
    localparam int unsigned TO        = 8;

    logic           clk = 1'b0;
    logic           rst_i;
    axi_lite_req_t  req;
    axi_lite_resp_t rsp;
    logic [63:0]    reg_addr, reg_wdata, reg_rdata;
    logic [7:0]     reg_wstrb;
    logic           reg_valid, reg_write, reg_ready, reg_error;

    int n_checks = 0;
    int n_errors = 0;
    bit last_write_m;

    always #5 clk = ~clk;

    axi_lite_reg_bridge #(
        .AXI_ADDR_WIDTH (64),
        .AXI_DATA_WIDTH (64),
        .REG_BYTES      (REG_BYTES),
        .TIMEOUT_CYCLES (TO),
        .axi_req_t      (axi_lite_req_t),
        .axi_resp_t     (axi_lite_resp_t)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .axi_req_i   (req),
        .axi_resp_o  (rsp),
        .reg_addr_o  (reg_addr),
        .reg_valid_o (reg_valid),
        .reg_write_o (reg_write),
        .reg_wdata_o (reg_wdata),
        .reg_wstrb_o (reg_wstrb),
        .reg_rdata_i (reg_rdata),
        .reg_ready_i (reg_ready),
        .reg_error_i (reg_error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_aw_ready"}, rsp.aw_ready, 0);
        check({tag, "_w_ready"}, rsp.w_ready, 0);
        check({tag, "_ar_ready"}, rsp.ar_ready, 0);
        check({tag, "_b_valid"}, rsp.b_valid, 0);
        check({tag, "_r_valid"}, rsp.r_valid, 0);
        check({tag, "_b_resp"}, rsp.b_resp, 0);
        check({tag, "_r_resp"}, rsp.r_resp, 0);
        check({tag, "_r_data"}, rsp.r_data, 0);
        check({tag, "_reg_valid"}, reg_valid, 0);
        check({tag, "_reg_addr"}, reg_addr, 0);
        check({tag, "_reg_write"}, reg_write, 0);
        check({tag, "_reg_wdata"}, reg_wdata, 0);
        check({tag, "_reg_wstrb"}, reg_wstrb, 0);
    endtask

    // One complete transaction; when contest is set both AW/W and AR are offered and the
    // model's alternation rule decides which one must be taken.
    task automatic xfer(input bit want_wr, input bit contest, input logic [63:0] addr,
                        input logic [63:0] data, input logic [7:0] strb,
                        input int waits, input bit err, input int resp_wait);
        bit         is_wr;
        bit         dec;
        logic [1:0] exp_resp;
        is_wr    = contest ? !last_write_m : want_wr;
        dec      = (addr >= 64'(REG_BYTES));
        exp_resp = dec ? 2'b11 : (err ? 2'b10 : 2'b00);

        @(negedge clk);
        if (is_wr || contest) begin
            req.aw_valid = 1'b1;
            req.aw_addr  = addr;
            req.w_valid  = 1'b1;
            req.w_data   = data;
            req.w_strb   = strb;
        end
        if (!is_wr || contest) begin
            req.ar_valid = 1'b1;
            req.ar_addr  = addr;
        end
        #1;
        check("aw_ready", rsp.aw_ready, is_wr);
        check("w_ready", rsp.w_ready, is_wr);
        check("ar_ready", rsp.ar_ready, !is_wr);
        last_write_m = is_wr;

        @(negedge clk);
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        req.ar_valid = 1'b0;
        if (!dec) begin
            for (int i = 0; i <= waits; i++) begin
                if (i == waits) begin
                    reg_ready = 1'b1;
                    reg_error = err;
                    reg_rdata = data;
                end
                #1;
                check("reg_valid", reg_valid, 1);
                check("reg_write", reg_write, is_wr);
                check("reg_addr", reg_addr, addr & ~64'h7);
                check("reg_wstrb", reg_wstrb, is_wr ? strb : 8'h00);
                if (is_wr) check("reg_wdata", reg_wdata, data);
                @(negedge clk);
            end
            reg_ready = 1'b0;
            reg_error = 1'b0;
        end

        for (int i = 0; i <= resp_wait; i++) begin
            if (i == resp_wait) begin
                if (is_wr) req.b_ready = 1'b1;
                else       req.r_ready = 1'b1;
            end
            #1;
            check("reg_valid_in_resp", reg_valid, 0);
            if (is_wr) begin
                check("b_valid", rsp.b_valid, 1);
                check("b_resp", rsp.b_resp, exp_resp);
            end else begin
                check("r_valid", rsp.r_valid, 1);
                check("r_resp", rsp.r_resp, exp_resp);
                check("r_data", rsp.r_data, dec ? 64'h0 : data);
            end
            @(negedge clk);
        end
        req.b_ready = 1'b0;
        req.r_ready = 1'b0;
        #1;
        check("resp_done", is_wr ? rsp.b_valid : rsp.r_valid, 0);
    endtask

    initial begin
        rst_i     = 1'b1;
        req       = '0;
        reg_ready = 1'b0;
        reg_error = 1'b0;
        reg_rdata = '0;
        last_write_m = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        #1;
        check_idle("reset");

        // Four contested transactions straight out of reset: W, R, W, R.
        for (int k = 0; k < 4; k++) begin
            xfer(1'b0, 1'b1, 64'h100 + 64'(k * 8), 64'hA5A5_0000 + 64'(k), 8'hFF, k, 1'b0, 0);
            check("arb_order", last_write_m, (k % 2 == 0));
        end

        xfer(1'b1, 1'b0, 64'h10, 64'hDEAD_BEEF, 8'h0F, 0, 1'b0, 0);

        // W offered alone first, then AW, then W three cycles later.
        @(negedge clk);
        req.w_valid = 1'b1;
        req.w_data  = 64'h0123_4567_89AB_CDEF;
        req.w_strb  = 8'hF0;
        #1;
        check("w_before_aw", rsp.w_ready, 0);
        @(negedge clk);
        req.w_valid  = 1'b0;
        req.aw_valid = 1'b1;
        req.aw_addr  = 64'h48;
        #1;
        check("aw_only_aw_ready", rsp.aw_ready, 1);
        check("aw_only_w_ready", rsp.w_ready, 0);
        @(negedge clk);
        req.aw_valid = 1'b0;
        for (int i = 1; i < 3; i++) begin
            #1;
            check("wdata_wait_w_ready", rsp.w_ready, 0);
            check("wdata_wait_reg_valid", reg_valid, 0);
            @(negedge clk);
        end
        req.w_valid = 1'b1;
        #1;
        check("late_w_ready", rsp.w_ready, 1);
        check("late_w_reg_valid", reg_valid, 0);
        @(negedge clk);
        req.w_valid = 1'b0;
        reg_ready   = 1'b1;
        #1;
        check("late_w_reg_valid_c4", reg_valid, 1);
        check("late_w_reg_addr", reg_addr, 64'h48);
        check("late_w_reg_wdata", reg_wdata, 64'h0123_4567_89AB_CDEF);
        check("late_w_reg_wstrb", reg_wstrb, 8'hF0);
        @(negedge clk);
        reg_ready   = 1'b0;
        req.b_ready = 1'b1;
        #1;
        check("late_w_b_valid", rsp.b_valid, 1);
        check("late_w_b_resp", rsp.b_resp, 2'b00);
        @(negedge clk);
        req.b_ready = 1'b0;
        last_write_m = 1'b1;

        xfer(1'b0, 1'b0, 64'h1004, 64'h1234, 8'h00, 5, 1'b0, 3);
        xfer(1'b0, 1'b0, 64'(REG_BYTES), 64'h7777, 8'h00, 0, 1'b0, 0);
        xfer(1'b1, 1'b0, 64'(REG_BYTES) + 64'h40, 64'h9999, 8'hFF, 0, 1'b0, 1);
        xfer(1'b1, 1'b0, 64'h200, 64'h5555, 8'h3C, 2, 1'b1, 0);
        xfer(1'b0, 1'b0, 64'h208, 64'h6666, 8'h00, 1, 1'b1, 0);

`ifdef AXI_LITE_REG_TIMEOUT_EN
        xfer(1'b0, 1'b0, 64'h28, 64'h55AA, 8'h00, TO, 1'b0, 0);
        @(negedge clk);
        req.ar_valid = 1'b1;
        req.ar_addr  = 64'h30;
        #1;
        check("to_ar_ready", rsp.ar_ready, 1);
        @(negedge clk);
        req.ar_valid = 1'b0;
        for (int i = 0; i < int'(TO) + 1; i++) begin
            #1;
            check("to_reg_valid", reg_valid, 1);
            @(negedge clk);
        end
        #1;
        check("to_reg_dropped", reg_valid, 0);
        check("to_r_valid", rsp.r_valid, 1);
        check("to_r_resp", rsp.r_resp, 2'b10);
        check("to_r_data", rsp.r_data, 0);
        req.r_ready = 1'b1;
        @(negedge clk);
        req.r_ready = 1'b0;
        #1;
        check("to_r_done", rsp.r_valid, 0);
        last_write_m = 1'b0;
`endif

        // Reset in the middle of a register access.
        @(negedge clk);
        req.ar_valid = 1'b1;
        req.ar_addr  = 64'h40;
        @(negedge clk);
        req.ar_valid = 1'b0;
        #1;
        check("mid_reg_valid", reg_valid, 1);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        #1;
        check_idle("mid_reset");
        last_write_m = 1'b0;
        xfer(1'b0, 1'b1, 64'h60, 64'hCAFE, 8'h81, 0, 1'b0, 0);
        check("post_reset_write_wins", last_write_m, 1);

        for (int n = 0; n < 40; n++) begin
            logic [63:0] addr;
            logic [63:0] data;
            addr = ($urandom_range(0, 9) == 0) ? 64'(REG_BYTES) + 64'($urandom_range(0, 255))
                                               : 64'($urandom_range(0, REG_BYTES - 1));
            data = {$urandom, $urandom};
            xfer(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), addr, data,
                 8'($urandom), $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                 $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
